// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory boot loader.
package imem_loader_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CHECK,
    ERROR
  } loader_state_e;

  // Big-endian packing: the newest byte lands in the LSB, earlier bytes move up.
  function automatic logic [WORD_W-1:0] be_assemble(input logic [WORD_W-1:0] acc,
                                                    input logic [BYTE_W-1:0] b);
    return {acc[WORD_W-BYTE_W-1:0], b};
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and imem write port of the boot loader.
interface imem_boot_loader_if #(
  parameter int unsigned ADDR_W = 6
);
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  modport master (output byte_data, byte_valid,
                  input  byte_ready, mem_we, mem_waddr, mem_wdata);
  modport slave  (input  byte_data, byte_valid,
                  output byte_ready, mem_we, mem_waddr, mem_wdata);
endinterface

// File: rtl/imem_boot_loader_byte_packer.sv
// Shift register plus byte counter; flags the handshake that completes a word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              word_valid_c,
  output logic [WORD_W-1:0] word_c
);

  localparam int unsigned CNT_W = $clog2(WORD_BYTES);

  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;

  always_comb begin
    shift_d      = shift_q;
    byte_cnt_d   = byte_cnt_q;
    word_c       = be_assemble(shift_q, in_byte);
    word_valid_c = in_valid && (byte_cnt_q == CNT_W'(WORD_BYTES - 1));
    if (clr) begin
      shift_d    = '0;
      byte_cnt_d = '0;
    end else if (in_valid) begin
      shift_d    = word_c;
      byte_cnt_d = byte_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
    end else begin
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: writes a big-endian byte image into imem, then releases core reset.
// Optional IMEM_LOADER_CHECKSUM_EN adds a trailing 32-bit sum check (CHECK/ERROR states).
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter  int unsigned DEPTH  = 64,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  imem_boot_loader_if.slave bus,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  loader_state_e     state_q, state_d;
  logic [CNT_W-1:0]  words_q, words_d, word_cnt_q, word_cnt_d, start_words_c;
  logic              reload_q, reload_d;
  logic              byte_ready_q, byte_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d, done_q, done_d, cpu_rst_n_q, cpu_rst_n_d;
  logic              hs_c, pack_clr_c, word_valid_c;
  logic [WORD_W-1:0] word_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum_q, sum_d;
  logic              err_q, err_d;
`endif

  assign hs_c          = bus.byte_valid && byte_ready_q;
  assign start_words_c = (num_words > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : num_words;

  byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (pack_clr_c),
    .in_valid     (hs_c),
    .in_byte      (bus.byte_data),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  always_comb begin
    state_d      = state_q;
    words_d      = words_q;
    word_cnt_d   = word_cnt_q;
    reload_d     = reload_q;
    byte_ready_d = byte_ready_q;
    mem_we_d     = 1'b0;
    mem_waddr_d  = mem_waddr_q;
    mem_wdata_d  = mem_wdata_q;
    pack_clr_c   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d        = sum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) words_d = start_words_c;
        // reload_q carries a start taken in RUN/ERROR through one reset-asserted cycle
        if (start || reload_q) begin
          reload_d   = 1'b0;
          word_cnt_d = '0;
          pack_clr_c = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
          if (words_d == '0) begin
            state_d = RUN;
          end else begin
            state_d      = LOAD;
            byte_ready_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (word_valid_c) begin
          mem_we_d    = 1'b1;
          mem_waddr_d = ADDR_W'(word_cnt_q);
          mem_wdata_d = word_c;
          word_cnt_d  = word_cnt_q + CNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d       = sum_q + word_c;
`endif
          if (word_cnt_d == words_q) byte_ready_d = 1'b0;
        end
        // leave once the final write pulse is on the port
        if (mem_we_q && (word_cnt_q == words_q)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d      = CHECK;
          byte_ready_d = 1'b1;
`else
          state_d      = RUN;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (word_valid_c) begin
          byte_ready_d = 1'b0;
          state_d      = (word_c == sum_q) ? RUN : ERROR;
        end
      end
`endif
      RUN, ERROR: begin
        if (start) begin
          words_d  = start_words_c;
          reload_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d == LOAD);
    done_d      = (state_d == RUN);
    cpu_rst_n_d = (state_d == RUN);
`ifdef IMEM_LOADER_CHECKSUM_EN
    err_d       = (state_d == ERROR);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      words_q      <= '0;
      word_cnt_q   <= '0;
      reload_q     <= 1'b0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cpu_rst_n_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      words_q      <= words_d;
      word_cnt_q   <= word_cnt_d;
      reload_q     <= reload_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
      err_q        <= err_d;
`endif
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_waddr  = mem_waddr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign cpu_rst_n      = cpu_rst_n_q;
  assign busy           = busy_q;
  assign done           = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign err            = err_q;
`else
  assign err            = 1'b0;
`endif

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time controller for the core's instruction memory: accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words, first byte = MSB, matching the .bin image byte order.
- Drives the write port of the instruction memory.
- Holds the core in reset until the programmed image is complete, then releases it.
- Sits between the host/UART byte source and the imem write port plus core reset.

Parameters:
- DEPTH, 64, instruction memory depth in 32-bit words.
- ADDR_W, $clog2(DEPTH), word address width (localparam, derived).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a load
- num_words  in  ADDR_W+1  words to load; sampled on start
- byte_data  in  8  stream byte
- byte_valid  in  1  stream byte valid
- byte_ready  out  1  loader accepts byte
- mem_we  out  1  imem write enable, one-cycle pulse per word
- mem_waddr  out  ADDR_W  imem word address
- mem_wdata  out  32  imem write data
- cpu_rst_n  out  1  core reset, active-low; 0 while not RUN
- busy  out  1  high in LOAD
- done  out  1  high in RUN
- err  out  1  checksum mismatch flag (feature only)

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all outputs 0, including cpu_rst_n=0.
  - Internal counters and the shift register clear to 0.
- States IDLE, LOAD, RUN (+CHECK, ERROR with feature). All outputs registered.
- IDLE: byte_ready=0; byte_valid ignored. On start, latch words = min(num_words, DEPTH):
  - words==0: go to RUN next cycle.
  - otherwise: go to LOAD; byte_ready=1 from the next cycle; byte_cnt=0, word_cnt=0.
- LOAD, byte handshake (byte_valid && byte_ready):
  - shift = {shift[23:0], byte_data}; byte_cnt++ mod 4.
  - byte_valid without byte_ready is ignored; byte_ready never depends combinationally on byte_valid.
- LOAD, word write:
  - On the 4th byte handshake, the next cycle shows mem_we=1, mem_waddr=word_cnt, mem_wdata=assembled word; word_cnt++.
  - No bubble: byte_ready stays 1, so back-to-back bytes are allowed during the mem_we cycle.
- LOAD exit:
  - On the handshake of the final byte of word words-1, byte_ready drops next cycle, together with the final mem_we pulse.
  - State becomes RUN the cycle after that final mem_we.
- mem_waddr/mem_wdata hold their last values when mem_we=0.
- RUN: cpu_rst_n=1, done=1, byte_ready=0.
- start in RUN (reload): next cycle cpu_rst_n=0, done=0, then behaves as start from IDLE.
- start in LOAD is ignored.
- Partial word (stream stalls): the loader waits indefinitely. Only rst_n aborts; after reset, cpu_rst_n stays 0 until a new load completes.
- num_words > DEPTH: clamped to DEPTH; addresses never wrap.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A 32-bit running sum (mod 2^32) accumulates every written word.
  - After the last word, state CHECK accepts 4 more bytes (big-endian) as the expected sum.
  - Match: go to RUN.
  - Mismatch: go to ERROR with err=1, cpu_rst_n=0, byte_ready=0. Only start (reload) or rst_n leave ERROR; start clears err.
  - words==0 still goes straight to RUN without a checksum.
- Undefined: no CHECK/ERROR states; err tied 0.

Decomposition:
- Package imem_loader_pkg:
  - state enum loader_state_e (IDLE, LOAD, RUN, CHECK, ERROR).
  - WORD_BYTES=4 constant.
  - function be_assemble for byte-to-word packing.
- One sub-module, byte_packer: shift register + byte counter emitting word_valid/word.
- Top holds FSM, word counter, outputs.

Test Plan:
- Reset mid-LOAD after 6 bytes -> all outputs 0 immediately.
  - cpu_rst_n stays 0; a fresh start with num_words=1 writes addr 0 correctly.
- start, num_words=2, bytes 00 00 00 13 DE AD BE EF back-to-back ->
  - mem_we pulses with (0, 0x00000013) and (1, 0xDEADBEEF).
  - RUN and cpu_rst_n=1 the cycle after the 2nd pulse.
- Same stream with byte_valid toggling every other cycle -> identical writes; no byte lost or duplicated.
- num_words=0 -> RUN one cycle after start, no mem_we.
- num_words=100 with DEPTH=64 -> exactly 64 writes, addresses 0..63, then RUN.
- Checksum (feature on): 1 word 0x00000005 followed by 00 00 00 05 -> RUN.
  - Followed by 00 00 00 06 instead -> ERROR, err=1, cpu_rst_n=0.
  - Then start with num_words=0 -> err clears, RUN.
